// File: rtl/hilo_muldiv_unit.sv
// ============================================================================
// hilo_muldiv_unit
// ----------------------------------------------------------------------------
// HI/LO register pair with an integrated multi-cycle multiply/divide engine.
// It executes MULT/MULTU/DIV/DIVU and MTHI/MTLO issued from the EX stage,
// exposes HI/LO to MFHI/MFLO readers and back-pressures issue while busy.
//
// Parameters
//   WIDTH        operand width; HI and LO are each WIDTH bits
//   MUL_LATENCY  multiply depth in cycles (>= 1)
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous, active-high reset (aborts any op)
//   op_valid  in   operation request
//   op_ready  out  unit can accept an op this cycle (= !busy)
//   op_code   in   0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                  7 reserved (NOP)
//   src_a     in   multiplicand / dividend / MTHI-MTLO data
//   src_b     in   multiplier / divisor
//   flush     in   abandon the in-flight op, blocks acceptance this cycle
//   busy      out  multiply/divide in progress
//   done      out  one-cycle pulse in the cycle after a mul/div commit
//   hi_o      out  current HI (registered)
//   lo_o      out  current LO (registered)
// ============================================================================
module hilo_muldiv_unit #(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   // The step counter has to reach WIDTH for the divider and
   // MUL_LATENCY-1 for the multiplier, whichever is larger.
   localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LATENCY - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV
   } state_t;

   state_t state;
   state_t next_state;

   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;

   // op_a holds the multiplicand, or the dividend magnitude that is shifted
   // out while quotient bits shift in; op_b holds multiplier or divisor.
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   rem;
   logic               mul_signed;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;
   logic [WIDTH-1:0]   dividend;

   logic               accept;
   logic               last_step;
   logic               commit;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

   logic [2*WIDTH-1:0] mul_ext_a;
   logic [2*WIDTH-1:0] mul_ext_b;
   logic [2*WIDTH-1:0] product;

   logic [WIDTH:0]     rem_shift;
   logic [WIDTH:0]     rem_diff;
   logic               fits;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // State register: reset and flush both land the FSM in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: MTHI/MTLO complete in IDLE; mul/div leave IDLE and
   // return on the commit edge or when flushed.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept && (op_code == OP_MULT || op_code == OP_MULTU)) begin
               next_state = MUL;
            end else if (accept && (op_code == OP_DIV || op_code == OP_DIVU)) begin
               next_state = DIV;
            end
         end
         MUL, DIV: begin
            if (flush || last_step) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output / control decode. Flush dominates both acceptance and commit so
   // a flushed op can never write HI/LO.
   always_comb begin
      busy      = (state != IDLE);
      op_ready  = !busy;
      accept    = op_valid && op_ready && !flush &&
                  (op_code >= OP_MULT) && (op_code <= OP_MTLO);
      last_step = ((state == MUL) && (cnt == MUL_LAST)) ||
                  ((state == DIV) && (cnt == DIV_LAST));
      commit    = last_step && !flush;
      done      = done_q;
      hi_o      = hi_q;
      lo_o      = lo_q;
   end

   // Operand conditioning for the divider: signed ops work on magnitudes and
   // the signs are restored at commit.
   always_comb begin
      a_neg = (op_code == OP_DIV) && src_a[WIDTH-1];
      b_neg = (op_code == OP_DIV) && src_b[WIDTH-1];
      a_mag = a_neg ? -src_a : src_a;
      b_mag = b_neg ? -src_b : src_b;
   end

   // Full double-width product; sign extension makes one unsigned multiply
   // serve both MULT and MULTU.
   always_comb begin
      mul_ext_a = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
      mul_ext_b = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
      product   = mul_ext_a * mul_ext_b;
   end

   // One restoring-division step: shift the next dividend bit into the
   // partial remainder and subtract the divisor if it fits. The remainder is
   // always below the divisor, so the difference's top bit is a clean sign.
   always_comb begin
      rem_shift = {rem, op_a[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, op_b};
      fits      = !rem_diff[WIDTH];
      rem_next  = fits ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      quo_fix   = neg_q ? -op_a : op_a;
      rem_fix   = neg_r ? -rem : rem;
   end

   // Datapath: HI/LO writes, operand capture on acceptance, per-cycle
   // divide steps, and the single commit write. HI/LO only change on an
   // MTHI/MTLO acceptance or a commit, never part way through an op.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         cnt        <= '0;
         op_a       <= '0;
         op_b       <= '0;
         rem        <= '0;
         mul_signed <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         div_zero   <= 1'b0;
         dividend   <= '0;
      end else begin
         done_q <= commit;
         if (accept) begin
            cnt <= '0;
            case (op_code)
               OP_MTHI: hi_q <= src_a;
               OP_MTLO: lo_q <= src_a;
               OP_MULT, OP_MULTU: begin
                  op_a       <= src_a;
                  op_b       <= src_b;
                  mul_signed <= (op_code == OP_MULT);
               end
               OP_DIV, OP_DIVU: begin
                  op_a     <= a_mag;
                  op_b     <= b_mag;
                  rem      <= '0;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  div_zero <= (src_b == '0);
                  dividend <= src_a;
               end
               default: ;
            endcase
         end else if (busy && !flush) begin
            if (commit) begin
               if (state == MUL) begin
                  {hi_q, lo_q} <= product;
               end else if (div_zero) begin
                  hi_q <= dividend;
                  lo_q <= '1;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
            end else begin
               cnt <= cnt + CW'(1);
               if (state == DIV) begin
                  rem  <= rem_next;
                  op_a <= {op_a[WIDTH-2:0], fits};
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// ============================================================================
// tb_hilo_muldiv_unit
// ----------------------------------------------------------------------------
// Self-checking bench for hilo_muldiv_unit: a table of directed operations
// with hand-computed HI/LO results, followed by hand-written sequences for
// busy back-pressure, flush, flush-vs-issue and reset during a multiply.
// ============================================================================
module tb_hilo_muldiv_unit;

   localparam int WIDTH       = 32;
   localparam int MUL_LATENCY = 3;
   localparam int NUM_VECS    = 17;
   localparam int TIMEOUT     = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             op_valid;
   logic             op_ready;
   logic [2:0]       op_code;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] hi;
      logic [WIDTH-1:0] lo;
   } vec_t;

   vec_t vecs [NUM_VECS];

   hilo_muldiv_unit #(
      .WIDTH       (WIDTH),
      .MUL_LATENCY (MUL_LATENCY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .op_code  (op_code),
      .src_a    (src_a),
      .src_b    (src_b),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .hi_o     (hi_o),
      .lo_o     (lo_o)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Word-sized comparison
   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Single-bit comparison
   task automatic checkBit(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
      end
   endtask

   // Presents one op for exactly one clock edge (E0) and returns #1 after it
   task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b);
      op_valid = 1'b1;
      op_code  = op;
      src_a    = a;
      src_b    = b;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op_code  = 3'd0;
   endtask

   // Waits for done (bounded), counting edges after E0 and noting whether
   // HI/LO moved before the commit
   task automatic waitDone(input logic [WIDTH-1:0] old_hi, input logic [WIDTH-1:0] old_lo,
                           output int edges, output logic held);
      edges = 0;
      held  = 1'b1;
      while (!done && edges < TIMEOUT) begin
         if (hi_o !== old_hi || lo_o !== old_lo) held = 1'b0;
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   initial begin
      int               edges;
      logic             held;
      logic             saw_done;
      logic [WIDTH-1:0] old_hi;
      logic [WIDTH-1:0] old_lo;
      vec_t             v;

      // Directed vectors, applied back to back; expected HI/LO carry over
      vecs[0]  = '{op: 3'd5, a: 32'h1234_5678, b: 32'h0,         hi: 32'h1234_5678, lo: 32'h0000_0000};
      vecs[1]  = '{op: 3'd6, a: 32'h9ABC_DEF0, b: 32'h0,         hi: 32'h1234_5678, lo: 32'h9ABC_DEF0};
      vecs[2]  = '{op: 3'd0, a: 32'hDEAD_BEEF, b: 32'h1,         hi: 32'h1234_5678, lo: 32'h9ABC_DEF0};
      vecs[3]  = '{op: 3'd1, a: 32'hFFFF_FFFD, b: 32'h5,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFF1};
      vecs[4]  = '{op: 3'd2, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001};
      vecs[5]  = '{op: 3'd1, a: 32'h7FFF_FFFF, b: 32'h2,         hi: 32'h0000_0000, lo: 32'hFFFF_FFFE};
      vecs[6]  = '{op: 3'd1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h0000_0001};
      vecs[7]  = '{op: 3'd2, a: 32'h8000_0000, b: 32'h2,         hi: 32'h0000_0001, lo: 32'h0000_0000};
      vecs[8]  = '{op: 3'd3, a: 32'hFFFF_FFF9, b: 32'h2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD};
      vecs[9]  = '{op: 3'd4, a: 32'h0000_0007, b: 32'h0,         hi: 32'h0000_0007, lo: 32'hFFFF_FFFF};
      vecs[10] = '{op: 3'd3, a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0000_0000, lo: 32'h8000_0000};
      vecs[11] = '{op: 3'd3, a: 32'h0000_0007, b: 32'hFFFF_FFFE, hi: 32'h0000_0001, lo: 32'hFFFF_FFFD};
      vecs[12] = '{op: 3'd4, a: 32'h0000_0064, b: 32'h7,         hi: 32'h0000_0002, lo: 32'h0000_000E};
      vecs[13] = '{op: 3'd3, a: 32'hFFFF_FFFB, b: 32'h0,         hi: 32'hFFFF_FFFB, lo: 32'hFFFF_FFFF};
      vecs[14] = '{op: 3'd7, a: 32'h0000_0001, b: 32'h1,         hi: 32'hFFFF_FFFB, lo: 32'hFFFF_FFFF};
      vecs[15] = '{op: 3'd4, a: 32'hFFFF_FFFF, b: 32'h10,        hi: 32'h0000_000F, lo: 32'h0FFF_FFFF};
      vecs[16] = '{op: 3'd3, a: 32'hFFFF_FF9C, b: 32'h7,         hi: 32'hFFFF_FFFE, lo: 32'hFFFF_FFF2};

      rst      = 1'b1;
      op_valid = 1'b0;
      op_code  = 3'd0;
      src_a    = '0;
      src_b    = '0;
      flush    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset hi", hi_o, 32'h0);
      checkOutput("reset lo", lo_o, 32'h0);
      checkBit("reset busy", busy, 1'b0);
      checkBit("reset done", done, 1'b0);
      checkBit("reset op_ready", op_ready, 1'b1);

      // Table: each op is issued in the cycle the previous one finished,
      // which for mul/div is the done cycle
      $display("[TB] directed vectors");
      for (int i = 0; i < NUM_VECS; i++) begin
         v      = vecs[i];
         old_hi = hi_o;
         old_lo = lo_o;
         checkBit($sformatf("v%0d ready", i), op_ready, 1'b1);
         applyStimulus(v.op, v.a, v.b);
         checkBit($sformatf("v%0d done low at E0+1", i), done, 1'b0);
         if (v.op >= 3'd1 && v.op <= 3'd4) begin
            checkBit($sformatf("v%0d busy", i), busy, 1'b1);
            waitDone(old_hi, old_lo, edges, held);
            checkOutput($sformatf("v%0d latency", i), edges,
                        (v.op <= 3'd2) ? MUL_LATENCY : WIDTH + 1);
            checkBit($sformatf("v%0d hold", i), held, 1'b1);
            checkBit($sformatf("v%0d ready in done cycle", i), op_ready, 1'b1);
         end else begin
            checkBit($sformatf("v%0d busy", i), busy, 1'b0);
         end
         checkOutput($sformatf("v%0d hi", i), hi_o, v.hi);
         checkOutput($sformatf("v%0d lo", i), lo_o, v.lo);
      end

      // MTHI held while a DIV is busy must be ignored
      $display("[TB] issue while busy");
      applyStimulus(3'd3, 32'h0000_0064, 32'h7);
      op_valid = 1'b1;
      op_code  = 3'd5;
      src_a    = 32'h0000_DEAD;
      repeat (5) @(posedge clk);
      #1;
      checkBit("busy ignore op_ready", op_ready, 1'b0);
      checkOutput("busy ignore hi", hi_o, 32'hFFFF_FFFE);
      op_valid = 1'b0;
      op_code  = 3'd0;
      waitDone(32'hFFFF_FFFE, 32'hFFFF_FFF2, edges, held);
      checkBit("busy ignore done", done, 1'b1);
      checkOutput("busy ignore div hi", hi_o, 32'h2);
      checkOutput("busy ignore div lo", lo_o, 32'hE);

      // Flush in cycle 10 of a DIV
      $display("[TB] flush");
      applyStimulus(3'd5, 32'h55, 32'h0);
      applyStimulus(3'd6, 32'h55, 32'h0);
      applyStimulus(3'd4, 32'h64, 32'h7);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkBit("flush busy", busy, 1'b0);
      checkBit("flush op_ready", op_ready, 1'b1);
      checkBit("flush done", done, 1'b0);
      checkOutput("flush hi", hi_o, 32'h55);
      checkOutput("flush lo", lo_o, 32'h55);
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done;
      end
      checkBit("flush no done", saw_done, 1'b0);
      checkOutput("flush hi later", hi_o, 32'h55);

      // Flush and op_valid together: nothing is accepted
      op_valid = 1'b1;
      op_code  = 3'd5;
      src_a    = 32'h99;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op_code  = 3'd0;
      flush    = 1'b0;
      checkOutput("flush wins hi", hi_o, 32'h55);
      checkBit("flush wins busy", busy, 1'b0);

      applyStimulus(3'd1, 32'h2, 32'h3);
      waitDone(32'h55, 32'h55, edges, held);
      checkOutput("post-flush mult lo", lo_o, 32'h6);
      checkOutput("post-flush mult hi", hi_o, 32'h0);

      // Reset during a multiply
      $display("[TB] reset mid-MUL");
      applyStimulus(3'd5, 32'h77, 32'h0);
      applyStimulus(3'd1, 32'h4, 32'h5);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst hi", hi_o, 32'h0);
      checkOutput("rst lo", lo_o, 32'h0);
      checkBit("rst busy", busy, 1'b0);
      checkBit("rst op_ready", op_ready, 1'b1);
      checkBit("rst done", done, 1'b0);
      saw_done = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         saw_done = saw_done | done;
      end
      checkBit("rst no done", saw_done, 1'b0);
      checkOutput("rst lo later", lo_o, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
